instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Instruction-cycle controller for the PIC16F84-style core. Steps the four-phase cycle
//  FETCH/DECODE/EXEC/WB and drives the fetch, decode, execute and write-back enables.
//  Owns the program counter, the hardware return stack, skip handling and interrupt entry.
//  Sits between program memory, the decode stage (en/opcode/operand/sel) and the ALU/register-file datapath.
// PARAMETERS
//  PC_WIDTH     10   program counter / memory address width
//  STACK_DEPTH  8    return-stack entries (power of 2)
//  RESET_VECTOR 0    PC loaded by reset
//  INT_VECTOR   4    PC loaded on interrupt entry
// PORTS
//  clock     in  1   rising-edge clock
//  reset     in  1   synchronous, active-high reset
//  run       in  1   1 = execute instructions; 0 = stop at next instruction boundary
//  opcode    in  5   decode-stage opcode; valid in EXEC
//  operand   in  10  decode-stage operand; valid in EXEC
//  sel       in  2   decode-stage select; 2'b11 = illegal instruction
//  skip_cond in  1   datapath: skip required (BTFSC/BTFSS/DECFSZ/INCFSZ); sampled in EXEC
//  int_req   in  1   interrupt request, level-sensitive
//  gie_set   in  1   pulse: set global interrupt enable
//  gie_clr   in  1   pulse: clear global interrupt enable
//  pc        out PC_WIDTH  program-memory address, registered
//  fetch_en  out 1   program-memory read enable; word valid the following cycle
//  decode_en out 1   decode-stage en
//  exec_en   out 1   datapath execute strobe
//  wb_en     out 1   datapath write-back strobe
//  gie       out 1   global interrupt enable
//  busy      out 1   1 in any state except IDLE
//  illegal   out 1   sticky: illegal instruction seen
//  stack_ovf out 1   sticky: push while stack full
//  stack_unf out 1   sticky: pop while stack empty
// BEHAVIOUR
//  Reset (sync, highest priority, also mid-instruction): state=IDLE, pc=RESET_VECTOR, all other outputs 0,
//   stack pointer and count = 0.
//  FSM (Moore; enables decoded from the registered state):
//   IDLE -> FETCH when run=1.
//   FETCH (fetch_en=1) -> DECODE (decode_en=1) -> EXEC -> WB.
//   WB -> FETCH if run=1, else IDLE.
//  Timing: 4 clocks per instruction. First fetch_en occurs 1 cycle after run is seen in IDLE.
//  Illegal instruction (sel=2'b11 in EXEC):
//   exec_en=0 and wb_en=0 for this instruction; illegal<=1; instruction is treated as a NOP (pc+1).
//  Legal instructions: exec_en=1 in EXEC, wb_en=1 in WB.
//  Skip: skip_cond is captured in EXEC for opcodes 5,6,20,24 only; it is ignored for all other opcodes.
//  PC update, applied at the end of WB; all arithmetic is modulo 2^PC_WIDTH (0x3FF+1 = 0x000):
//   1  CALL          push pc+1; pc<=operand[PC_WIDTH-1:0]
//   2  GOTO          pc<=operand[PC_WIDTH-1:0]
//   8  RETLW         pc<=pop
//   31 RETURN        pc<=pop
//   0  RETFIE        pc<=pop; gie<=1 (decode stage emits 5'd0 for RETFIE)
//   5/6/20/24 skip   pc<=pc+2 if the captured skip=1, else pc+1
//   all others       pc<=pc+1
//  Stack: circular buffer of STACK_DEPTH entries.
//   Push when full: overwrites the oldest entry; stack_ovf<=1; count stays at STACK_DEPTH.
//   Pop when empty: returns the entry at the wrapped pointer; stack_unf<=1; count stays 0.
//  Interrupt: taken in WB if int_req=1, gie=1, the instruction is legal and not opcode 0/1/2/8/31.
//   Action: push the computed next pc; pc<=INT_VECTOR; gie<=0.
//   If any condition fails, the interrupt is deferred to the next instruction boundary.
//  gie priority: WB events (interrupt entry / RETFIE) > gie_clr > gie_set.
//  run deassert mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE.
//  Sticky flags clear only on reset.
// TESTING
//  1 reset; run=1; opcode=7 each instr -> fetch_en at cycles 1,5,9; pc 0,1,2; busy=1; run=0 -> IDLE after WB.
//  2 GOTO operand=10'h3FF -> pc=0x3FF; next opcode 7 -> pc=0x000 (wrap).
//  3 CALL 0x050 at pc 0x010, then RETURN -> pc=0x011. 9 nested CALLs -> stack_ovf=1.
//    Extra RETURN with the stack empty -> stack_unf=1.
//  4 BTFSC at pc 5: skip_cond=1 -> next pc 7; skip_cond=0 -> next pc 6. MOVLW with skip_cond=1 -> pc+1.
//  5 gie_set; int_req=1 during MOVLW at pc 0x020 -> pc=0x004, gie=0. RETFIE (opcode 0) -> pc=0x021, gie=1.
//  6 sel=2'b11 -> exec_en=0, wb_en=0, illegal=1, pc+1. Reset asserted in EXEC -> next cycle IDLE,
//    pc=0, all flags 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Four-phase instruction-cycle controller: FETCH/DECODE/EXEC/WB sequencing, program counter,
// circular return stack, skip handling and interrupt entry for a PIC16F84-style core.
module instr_sequencer #(
  parameter int PC_WIDTH     = 10,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [4:0]          opcode,
  input  logic [9:0]          operand,
  input  logic [1:0]          sel,
  input  logic                skip_cond,
  input  logic                int_req,
  input  logic                gie_set,
  input  logic                gie_clr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                wb_en,
  output logic                gie,
  output logic                busy,
  output logic                illegal,
  output logic                stack_ovf,
  output logic                stack_unf
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] stack_r [STACK_DEPTH];
  logic [SP_W-1:0]     sp_r;
  logic [SP_W:0]       cnt_r;
  logic [4:0]          opc_r;
  logic [PC_WIDTH-1:0] target_r;
  logic                legal_r;
  logic                skip_r;
  logic                gie_r;
  logic                illegal_r;
  logic                ovf_r;
  logic                unf_r;

  logic [PC_WIDTH-1:0] pc_inc1_s;
  logic [PC_WIDTH-1:0] pc_inc2_s;
  logic [PC_WIDTH-1:0] pop_val_s;
  logic [PC_WIDTH-1:0] seq_pc_s;
  logic [PC_WIDTH-1:0] next_pc_s;
  logic [PC_WIDTH-1:0] push_val_s;
  logic                call_s;
  logic                ret_s;
  logic                retfie_s;
  logic                flow_s;
  logic                int_take_s;
  logic                do_push_s;
  logic                do_pop_s;
  logic                full_s;
  logic                empty_s;
  logic                is_skip_op_s;
  logic                sel_illegal_s;

  assign pc_inc1_s     = pc_r + PC_WIDTH'(1);
  assign pc_inc2_s     = pc_r + PC_WIDTH'(2);
  assign pop_val_s     = stack_r[sp_r - SP_W'(1)];
  assign full_s        = (cnt_r == (SP_W+1)'(STACK_DEPTH));
  assign empty_s       = (cnt_r == (SP_W+1)'(0));
  assign sel_illegal_s = (sel == 2'b11);
  assign is_skip_op_s  = (opcode == 5'd5) || (opcode == 5'd6) ||
                         (opcode == 5'd20) || (opcode == 5'd24);

  // Write-back decode: sequential next pc, stack traffic and interrupt acceptance.
  always_comb begin
    seq_pc_s = pc_inc1_s;
    call_s   = 1'b0;
    ret_s    = 1'b0;
    retfie_s = 1'b0;
    flow_s   = 1'b0;
    if (legal_r) begin
      case (opc_r)
        5'd1: begin
          call_s   = 1'b1;
          flow_s   = 1'b1;
          seq_pc_s = target_r;
        end
        5'd2: begin
          flow_s   = 1'b1;
          seq_pc_s = target_r;
        end
        5'd0: begin
          ret_s    = 1'b1;
          retfie_s = 1'b1;
          flow_s   = 1'b1;
          seq_pc_s = pop_val_s;
        end
        5'd8, 5'd31: begin
          ret_s    = 1'b1;
          flow_s   = 1'b1;
          seq_pc_s = pop_val_s;
        end
        default: begin
          seq_pc_s = skip_r ? pc_inc2_s : pc_inc1_s;
        end
      endcase
    end else begin
      seq_pc_s = pc_inc1_s;
    end
    // Control-flow instructions defer a pending interrupt to the next boundary.
    int_take_s = (state_r == WB) && int_req && gie_r && legal_r && !flow_s;
    do_push_s  = (state_r == WB) && (call_s || int_take_s);
    do_pop_s   = (state_r == WB) && ret_s;
    push_val_s = int_take_s ? seq_pc_s : pc_inc1_s;
    next_pc_s  = int_take_s ? PC_WIDTH'(INT_VECTOR) : seq_pc_s;
  end

  // Sequencer state, pc, captured instruction, gie, return stack and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      pc_r      <= PC_WIDTH'(RESET_VECTOR);
      opc_r     <= 5'd0;
      target_r  <= '0;
      legal_r   <= 1'b0;
      skip_r    <= 1'b0;
      gie_r     <= 1'b0;
      illegal_r <= 1'b0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      sp_r      <= '0;
      cnt_r     <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE:   state_r <= run ? FETCH : IDLE;
        FETCH:  state_r <= DECODE;
        DECODE: state_r <= EXEC;
        EXEC: begin
          opc_r    <= opcode;
          target_r <= operand[PC_WIDTH-1:0];
          legal_r  <= !sel_illegal_s;
          skip_r   <= skip_cond && is_skip_op_s && !sel_illegal_s;
          if (sel_illegal_s) begin
            illegal_r <= 1'b1;
          end
          state_r  <= WB;
        end
        WB: begin
          pc_r    <= next_pc_s;
          state_r <= run ? FETCH : IDLE;
        end
        default: state_r <= IDLE;
      endcase

      if (int_take_s) begin
        gie_r <= 1'b0;
      end else if ((state_r == WB) && retfie_s) begin
        gie_r <= 1'b1;
      end else if (gie_clr) begin
        gie_r <= 1'b0;
      end else if (gie_set) begin
        gie_r <= 1'b1;
      end

      // When full, sp already points at the oldest entry, so a push overwrites it.
      if (do_push_s) begin
        stack_r[sp_r] <= push_val_s;
        sp_r          <= sp_r + SP_W'(1);
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + (SP_W+1)'(1);
        end
      end else if (do_pop_s) begin
        sp_r <= sp_r - SP_W'(1);
        if (empty_s) begin
          unf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r - (SP_W+1)'(1);
        end
      end
    end
  end

  assign pc        = pc_r;
  assign fetch_en  = (state_r == FETCH);
  assign decode_en = (state_r == DECODE);
  assign exec_en   = (state_r == EXEC) && !sel_illegal_s;
  assign wb_en     = (state_r == WB) && legal_r;
  assign busy      = (state_r != IDLE);
  assign gie       = gie_r;
  assign illegal   = illegal_r;
  assign stack_ovf = ovf_r;
  assign stack_unf = unf_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed expectations checked with immediate assertions.
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [4:0] opcode;
  logic [9:0] operand;
  logic [1:0] sel;
  logic       skip_cond;
  logic       int_req;
  logic       gie_set;
  logic       gie_clr;
  logic [9:0] pc;
  logic       fetch_en, decode_en, exec_en, wb_en, gie, busy;
  logic       illegal, stack_ovf, stack_unf;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  instr_sequencer #(
    .PC_WIDTH(10), .STACK_DEPTH(8), .RESET_VECTOR(0), .INT_VECTOR(4)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .operand(operand),
    .sel(sel), .skip_cond(skip_cond), .int_req(int_req), .gie_set(gie_set),
    .gie_clr(gie_clr), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .wb_en(wb_en), .gie(gie), .busy(busy), .illegal(illegal),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one whole instruction starting from a FETCH cycle; gie pulses last one cycle.
  task automatic instr(input logic [4:0] opc, input logic [9:0] opr, input logic [1:0] s,
                       input logic sk, input logic ir);
    opcode    = opc;
    operand   = opr;
    sel       = s;
    skip_cond = sk;
    int_req   = ir;
    tick();
    gie_set = 1'b0;
    gie_clr = 1'b0;
    tick();
    tick();
    tick();
    skip_cond = 1'b0;
    int_req   = 1'b0;
    sel       = 2'b00;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 5'd7; operand = 10'd0; sel = 2'b00;
    skip_cond = 1'b0; int_req = 1'b0; gie_set = 1'b0; gie_clr = 1'b0;
    tick();
    tick();
    chk("rst_pc", {22'd0, pc}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fetch", {31'd0, fetch_en}, 32'd0);
    chk("rst_gie", {31'd0, gie}, 32'd0);

    // Basic four-phase sequencing
    reset = 1'b0; run = 1'b1;
    tick();
    chk("c1_fetch", {31'd0, fetch_en}, 32'd1);
    chk("c1_pc", {22'd0, pc}, 32'h0);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("c2_decode", {31'd0, decode_en}, 32'd1);
    chk("c2_fetch", {31'd0, fetch_en}, 32'd0);
    tick();
    chk("c3_exec", {31'd0, exec_en}, 32'd1);
    tick();
    chk("c4_wb", {31'd0, wb_en}, 32'd1);
    tick();
    chk("c5_fetch", {31'd0, fetch_en}, 32'd1);
    chk("c5_pc", {22'd0, pc}, 32'h1);
    instr(5'd7, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("c9_fetch", {31'd0, fetch_en}, 32'd1);
    chk("c9_pc", {22'd0, pc}, 32'h2);
    run = 1'b0;
    instr(5'd7, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_pc", {22'd0, pc}, 32'h3);

    // GOTO to the top of memory, then wrap
    run = 1'b1;
    tick();
    instr(5'd2, 10'h3FF, 2'b00, 1'b0, 1'b0);
    chk("goto_3ff", {22'd0, pc}, 32'h3FF);
    instr(5'd7, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("pc_wrap", {22'd0, pc}, 32'h000);

    // CALL / RETURN, overflow, underflow
    instr(5'd2, 10'h010, 2'b00, 1'b0, 1'b0);
    instr(5'd1, 10'h050, 2'b00, 1'b0, 1'b0);
    chk("call_pc", {22'd0, pc}, 32'h050);
    instr(5'd31, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("ret_pc", {22'd0, pc}, 32'h011);
    for (int i = 0; i < 8; i++) instr(5'd1, 10'h100, 2'b00, 1'b0, 1'b0);
    chk("ovf_8", {31'd0, stack_ovf}, 32'd0);
    instr(5'd1, 10'h100, 2'b00, 1'b0, 1'b0);
    chk("ovf_9", {31'd0, stack_ovf}, 32'd1);
    for (int i = 0; i < 8; i++) instr(5'd31, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("ret8_pc", {22'd0, pc}, 32'h101);
    chk("unf_8", {31'd0, stack_unf}, 32'd0);
    instr(5'd31, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("unf_9", {31'd0, stack_unf}, 32'd1);
    chk("unf_pc", {22'd0, pc}, 32'h101);

    // Skip handling
    instr(5'd2, 10'h005, 2'b00, 1'b0, 1'b0);
    instr(5'd5, 10'd0, 2'b00, 1'b1, 1'b0);
    chk("skip_taken", {22'd0, pc}, 32'h007);
    instr(5'd2, 10'h005, 2'b00, 1'b0, 1'b0);
    instr(5'd5, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("skip_not", {22'd0, pc}, 32'h006);
    instr(5'd12, 10'd0, 2'b00, 1'b1, 1'b0);
    chk("skip_ignored", {22'd0, pc}, 32'h007);

    // Interrupt entry and RETFIE
    gie_set = 1'b1;
    instr(5'd2, 10'h020, 2'b00, 1'b0, 1'b0);
    chk("gie_set", {31'd0, gie}, 32'd1);
    instr(5'd12, 10'd0, 2'b00, 1'b0, 1'b1);
    chk("int_pc", {22'd0, pc}, 32'h004);
    chk("int_gie", {31'd0, gie}, 32'd0);
    instr(5'd0, 10'd0, 2'b00, 1'b0, 1'b0);
    chk("retfie_pc", {22'd0, pc}, 32'h021);
    chk("retfie_gie", {31'd0, gie}, 32'd1);
    instr(5'd2, 10'h030, 2'b00, 1'b0, 1'b1);
    chk("int_defer_pc", {22'd0, pc}, 32'h030);
    chk("int_defer_gie", {31'd0, gie}, 32'd1);

    // Illegal instruction
    opcode = 5'd7; sel = 2'b11;
    tick();
    tick();
    chk("ill_exec", {31'd0, exec_en}, 32'd0);
    tick();
    chk("ill_wb", {31'd0, wb_en}, 32'd0);
    sel = 2'b00;
    tick();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_pc", {22'd0, pc}, 32'h031);

    // Reset in the middle of EXEC
    tick();
    tick();
    chk("pre_rst_exec", {31'd0, exec_en}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pc", {22'd0, pc}, 32'h0);
    chk("mid_rst_flags", {28'd0, illegal, stack_ovf, stack_unf, gie}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
